// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment hex display controller with static/blink/scroll/blank modes.
// Optional per-digit decimal points are compiled in with the HEX_DP_EN macro.
module hex_display_ctrl #(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [1:0]          mode,
`ifdef HEX_DP_EN
  input  logic [DIGITS-1:0]   dp,
`endif
  output logic [8*DIGITS-1:0] hex,
  output logic                tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ModeStatic = 2'b00,
    ModeBlink  = 2'b01,
    ModeScroll = 2'b10,
    ModeBlank  = 2'b11
  } mode_e;

  mode_e               mode_q, mode_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [2:0]          offset_q, offset_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [8*DIGITS-1:0] hex_q, hex_d;
  logic                mode_chg;
`ifdef HEX_DP_EN
  logic [DIGITS-1:0]   dp_q, dp_d;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick     = (cnt_q == CntW'(TICK_DIV - 1));
  assign mode_chg = (mode != mode_q);

  // A mode change restarts the whole sequence and swallows a coincident tick.
  always_comb begin
    mode_d   = mode_e'(mode);
    cnt_d    = cnt_q + CntW'(1);
    phase_d  = phase_q;
    offset_d = offset_q;
    shadow_d = load ? value : shadow_q;
`ifdef HEX_DP_EN
    dp_d     = load ? dp : dp_q;
`endif
    if (mode_chg) begin
      cnt_d    = '0;
      phase_d  = 1'b0;
      offset_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      if (mode_q == ModeBlink) begin
        phase_d = ~phase_q;
      end
      if (mode_q == ModeScroll) begin
        offset_d = (offset_q == 3'(DIGITS - 1)) ? 3'd0 : offset_q + 3'd1;
      end
    end
  end

  always_comb begin
    logic [3:0] sel;
    sel   = '0;
    hex_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      sel = 4'(i) + {1'b0, offset_q};
      if (sel >= 4'(DIGITS)) begin
        sel = sel - 4'(DIGITS);
      end
      hex_d[8*i +: 7] = seg7(shadow_q[4*sel +: 4]);
`ifdef HEX_DP_EN
      hex_d[8*i + 7] = ~dp_q[sel[2:0]];
`endif
    end
    if (mode_q == ModeBlank || (mode_q == ModeBlink && phase_q)) begin
      hex_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= ModeStatic;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      offset_q <= '0;
      shadow_q <= '0;
      hex_q    <= '1;
`ifdef HEX_DP_EN
      dp_q     <= '0;
`endif
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      offset_q <= offset_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
`ifdef HEX_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign hex = hex_q;

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 6, number of 7-segment digits; legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 25000000, clock cycles per display tick; minimum 2.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  strobe that captures value (and dp) into the shadow register.
REQ-006 SHALL have port value  input  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 at LSBs).
REQ-007 SHALL have port mode  input  2  display mode: 00 static, 01 blink, 10 scroll, 11 blank.
REQ-008 SHALL have port dp  input  DIGITS  decimal-point request per digit, 1 = lit (present only with HEX_DP_EN).
REQ-009 SHALL have port hex  output  8*DIGITS  active-low segments; byte i = digit i; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.
REQ-010 SHALL have port tick  output  1  one-cycle pulse on each prescaler wrap.

Function
REQ-011 Decode SHALL be, per nibble 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (hex, bit 7 = 1).
REQ-012 load=1 SHALL capture value into the shadow register at the clock edge; hex SHALL reflect it on the following edge (registered outputs, 1-cycle latency).
REQ-013 Prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for exactly the cycle in which it holds TICK_DIV-1.
REQ-014 Static (00): each digit i SHALL show decode(shadow nibble i).
REQ-015 Blink (01): phase bit SHALL toggle on each tick; phase=0 shows the static image; phase=1 drives all hex bits to 1.
REQ-016 Scroll (10): offset register SHALL increment on each tick, wrapping from DIGITS-1 to 0; digit i SHALL show nibble (i+offset) mod DIGITS.
REQ-017 Blank (11): all hex bits SHALL be 1; the prescaler and tick SHALL keep running.
REQ-018 Registered copy of mode SHALL be kept; on any cycle where mode differs from it, the prescaler, phase and offset SHALL clear to 0 and that cycle's tick effect SHALL be discarded.
REQ-019 load and tick in the same cycle SHALL both take effect (new data, advanced phase/offset).
REQ-020 load SHALL NOT alter prescaler, phase or offset.
REQ-021 DIGITS=1 scroll SHALL hold offset at 0.

Reset
REQ-022 With reset=1 at a clock edge: hex SHALL be all 1s, shadow value 0, dp shadow 0, prescaler 0, phase 0, offset 0, registered mode 00, tick 0.
REQ-023 reset SHALL take priority over load, mode change and tick; reset mid-scroll or mid-blink SHALL abandon the sequence.
REQ-024 First cycle after reset release SHALL display decode(0)=C0 on every digit if mode=00.

Configuration
REQ-025 Macro HEX_DP_EN defined: dp port exists, is captured on load, and hex bit 7 of digit i SHALL be ~dp shadow bit (i+offset) mod DIGITS, subject to blink/blank forcing 1.
REQ-026 HEX_DP_EN undefined: dp port and shadow SHALL be absent and hex bit 7 of every digit SHALL be constant 1.

Verification (DIGITS=6, TICK_DIV=4)
REQ-027 Reset, mode=00, load value=0x543210 -> hex = 0x92_99_B0_A4_F9_C0 two edges after the load strobe.
REQ-028 mode=01 after load 0x000001 -> tick every 4th cycle; hex alternates 0xC0C0C0C0C0F9 / 0xFFFFFFFFFFFF per tick.
REQ-029 mode=10, value 0x543210 -> after first tick digit 0 = F9, digit 5 = C0; after 6 ticks image returns to original.
REQ-030 Switch mode 10->00 after 3 ticks, then back to 10 -> offset restarts at 0, first tick 4 cycles after the change.
REQ-031 Assert reset during scroll with load=1 same cycle -> all outputs FF, shadow 0, tick 0 next cycle.
REQ-032 HEX_DP_EN defined, dp=6'b000001, mode=00 -> hex byte 0 = 0x40 for nibble 0; macro undefined -> byte 0 = 0xC0.
